// File: rtl/vga_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_framebuffer_scanout
// Description : Continuously reads a 160x120 pixel framebuffer through a
//               synchronous RAM port with one clock of read latency. The
//               block produces 640x480@60 VGA timing from CLOCK_50 using a
//               divide-by-2 pixel enable, and scales each framebuffer pixel
//               4x4 onto the screen.
// Ports       : clock        system clock (CLOCK_50)
//               resetn       asynchronous active-low reset
//               rd_addr      framebuffer read address, y*160+x (0 in blanking)
//               rd_data      RAM word {R,G,B}, valid 1 clock after rd_addr
//               frame_start  one-clock pulse while the (0,0) word is on rd_data
//               VGA_CLK      25 MHz pixel clock to the DAC
//               VGA_HS/VS    active-low syncs
//               VGA_BLANK    high in the visible region
//               VGA_SYNC     constant 1
//               VGA_R/G/B    10-bit DAC colour channels
// Revision    : 1.0 - initial release
// ============================================================================
module vga_framebuffer_scanout #(
    parameter int BITS_PER_COLOUR_CHANNEL = 1,
    parameter int H_VISIBLE               = 640,
    parameter int H_SYNC_START            = 656,
    parameter int H_SYNC_END              = 752,
    parameter int H_TOTAL                 = 800,
    parameter int V_VISIBLE               = 480,
    parameter int V_SYNC_START            = 490,
    parameter int V_SYNC_END              = 492,
    parameter int V_TOTAL                 = 525
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    output logic [14:0]                            rd_addr,
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0]   rd_data,
    output logic                                   frame_start,
    output logic                                   VGA_CLK,
    output logic                                   VGA_HS,
    output logic                                   VGA_VS,
    output logic                                   VGA_BLANK,
    output logic                                   VGA_SYNC,
    output logic [9:0]                             VGA_R,
    output logic [9:0]                             VGA_G,
    output logic [9:0]                             VGA_B
);

    localparam int B = BITS_PER_COLOUR_CHANNEL;

    // Counter-width copies of the timing parameters keep comparisons width-clean.
    localparam logic [9:0] H_VIS_C   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS_C    = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE_C    = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_C   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS_C    = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE_C    = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);

    // Channel tiling: replicate the channel enough times to cover 10 bits and
    // keep the top 10, which yields MSB-first repetition for any width.
    localparam int REPS  = (10 + B - 1) / B;
    localparam int REP_W = REPS * B;

    function automatic logic [9:0] tile(input logic [B-1:0] ch);
        logic [REP_W-1:0] rep;
        rep  = {REPS{ch}};
        return rep[REP_W-1 -: 10];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       phase_q, phase_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic [9:0] r_q, r_d;
    logic [9:0] g_q, g_d;
    logic [9:0] b_q, b_d;

    logic        pix_en;
    logic        visible;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] addr_full;

    assign pix_en  = phase_q;
    assign visible = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign x       = h_q[9:2];
    assign y       = v_q[8:2];

    // y*160 + x as two shifts and an add; clamped so blanking never
    // addresses past the end of the 19200-word memory.
    assign addr_full = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    assign rd_addr   = visible ? addr_full : 15'd0;

    // The pix_en cycle with (0,0) loaded is the one where word 0 is on rd_data.
    assign frame_start = pix_en && (h_q == 10'd0) && (v_q == 10'd0);

    // Pixel clock rises one clock after each output update.
    assign VGA_CLK   = phase_q;
    assign VGA_SYNC  = 1'b1;
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_BLANK = blank_q;
    assign VGA_R     = r_q;
    assign VGA_G     = g_q;
    assign VGA_B     = b_q;

    // ------------------------------------------------------------------
    // Next-state: counters advance and outputs capture on the same
    // pix_en edge, both from the (h,v) that addressed the current rd_data.
    // ------------------------------------------------------------------
    always_comb begin
        phase_d = ~phase_q;
        h_d     = h_q;
        v_d     = v_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;

        if (pix_en) begin
            if (h_q == H_LAST_C) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST_C) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end

            hs_d    = !((h_q >= H_SS_C) && (h_q < H_SE_C));
            vs_d    = !((v_q >= V_SS_C) && (v_q < V_SE_C));
            blank_d = visible;

            if (visible) begin
                r_d = tile(rd_data[3*B-1 -: B]);
                g_d = tile(rd_data[2*B-1 -: B]);
                b_d = tile(rd_data[B-1:0]);
            end else begin
                r_d = 10'd0;
                g_d = 10'd0;
                b_d = 10'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase_q <= 1'b0;
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            r_q     <= 10'd0;
            g_q     <= 10'd0;
            b_q     <= 10'd0;
        end else begin
            phase_q <= phase_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_framebuffer_scanout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_framebuffer_scanout
// Description : Self-checking bench for vga_framebuffer_scanout. A randomly
//               filled RAM model answers read requests; a time-based model
//               derives every expected output from the number of clocks
//               since reset release. Vertical timing is shortened so that
//               whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_framebuffer_scanout;

    localparam int BPC   = 1;
    localparam int MW    = 3 * BPC;
    localparam int HV    = 640;
    localparam int HSS   = 656;
    localparam int HSE   = 752;
    localparam int HT    = 800;
    localparam int VV    = 12;
    localparam int VSS   = 13;
    localparam int VSE   = 15;
    localparam int VT    = 16;
    localparam int FRAME = HT * VT;

    logic          clock;
    logic          resetn;
    logic [14:0]   rd_addr;
    logic [MW-1:0] rd_data;
    logic          frame_start;
    logic          VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
    logic [9:0]    VGA_R, VGA_G, VGA_B;

    vga_framebuffer_scanout #(
        .BITS_PER_COLOUR_CHANNEL(BPC),
        .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (
        .clock(clock), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_start(frame_start), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Synchronous RAM, one clock read latency.
    logic [MW-1:0] mem [0:32767];
    always @(posedge clock) rd_data <= mem[rd_addr];

    // Clocks since reset release: after edge c the bench is in cycle c.
    int cyc;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc = 0;
        else         cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;
    int printed = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (printed < 30) begin
                printed++;
                $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
            end
        end
    endtask

    function automatic int addr_of(input int h, input int v);
        if (h < HV && v < VV) return (v / 4) * 160 + (h / 4);
        return 0;
    endfunction

    function automatic logic [9:0] expand(input logic [BPC-1:0] ch);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) r[9-j] = ch[BPC-1 - (j % BPC)];
        return r;
    endfunction

    // Statistics of the first line / frame after each release.
    int hs_low_l1, blank_l1, vs_low_f1, hs_fall_c, fs_first, fs_second, fs_cnt;
    logic prev_hs;

    always @(negedge clock) begin : compare
        int c, n, m, h, v;
        logic [MW-1:0] w;
        logic [9:0] er, eg, eb;
        logic ehs, evs, ebl, efs, vis;
        logic [14:0] ea;
        if (!resetn) begin
            hs_low_l1 = 0; blank_l1 = 0; vs_low_f1 = 0;
            hs_fall_c = -1; fs_first = -1; fs_second = -1; fs_cnt = 0;
            prev_hs = 1'b1;
        end else begin
            c   = cyc;
            n   = (c / 2) % FRAME;
            ea  = 15'(addr_of(n % HT, n / HT));
            efs = (c % 2 == 1) && (n == 0);
            if (c < 2) begin
                ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
                er = '0; eg = '0; eb = '0;
            end else begin
                m   = (c / 2 - 1) % FRAME;
                h   = m % HT;
                v   = m / HT;
                vis = (h < HV) && (v < VV);
                ehs = !(h >= HSS && h < HSE);
                evs = !(v >= VSS && v < VSE);
                ebl = vis;
                w   = mem[addr_of(h, v)];
                er  = vis ? expand(w[3*BPC-1 -: BPC]) : 10'd0;
                eg  = vis ? expand(w[2*BPC-1 -: BPC]) : 10'd0;
                eb  = vis ? expand(w[BPC-1:0])        : 10'd0;
            end
            chk("scan",
                {13'd0, rd_addr, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B},
                {13'd0, ea, efs, 1'(c % 2), ehs, evs, ebl, 1'b1, er, eg, eb});

            // Address probes at hand-computed cycles (counter (h,v) loaded
            // at edge 2*(v*800+h), probed in the following odd cycle).
            if (c == 2*(4*HT+4)+1)    chk("addr_h4_v4",    64'(rd_addr), 64'd161);
            if (c == 2*(3*HT+3)+1)    chk("addr_h3_v3",    64'(rd_addr), 64'd0);
            if (c == 2*(1*HT+700)+1)  chk("addr_h700_v1",  64'(rd_addr), 64'd0);
            if (c == 2*(11*HT+639)+1) chk("addr_h639_v11", 64'(rd_addr), 64'd479);

            if (c >= 2 && c < 2 + 2*HT) begin
                if (!VGA_HS)   hs_low_l1++;
                if (VGA_BLANK) blank_l1++;
            end
            if (c >= 2 && c < 2 + 2*FRAME && !VGA_VS) vs_low_f1++;
            if (prev_hs && !VGA_HS && hs_fall_c < 0) hs_fall_c = c;
            prev_hs = VGA_HS;
            if (frame_start) begin
                if (fs_cnt == 0) fs_first = c;
                if (fs_cnt == 1) fs_second = c;
                fs_cnt++;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"},  64'(rd_addr), 64'd0);
        chk({tag, "_hsvs"},  64'({VGA_HS, VGA_VS}), 64'b11);
        chk({tag, "_blank"}, 64'(VGA_BLANK), 64'd0);
        chk({tag, "_rgb"},   64'({VGA_R, VGA_G, VGA_B}), 64'd0);
        chk({tag, "_fs"},    64'(frame_start), 64'd0);
        chk({tag, "_clk"},   64'(VGA_CLK), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_hs_low_clocks"},   64'(hs_low_l1), 64'd192);
        chk({tag, "_blank_hi_clocks"}, 64'(blank_l1),  64'd1280);
        chk({tag, "_vs_low_clocks"},   64'(vs_low_f1), 64'd3200);
        chk({tag, "_hs_fall_cycle"},   64'(hs_fall_c), 64'd1314);
        chk({tag, "_fs_first"},        64'(fs_first),  64'd1);
        chk({tag, "_fs_second"},       64'(fs_second), 64'd25601);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = MW'($urandom);
        repeat (3) @(negedge clock);
        #3 resetn = 1'b1;
        #1 check_reset_values("release1");

        // One full frame plus part of the next, then stop at (300,5):
        // position 12800+5*800+300 is loaded at edge 34200.
        while (cyc != 34200) @(negedge clock);
        check_stats("run1");
        chk("blank_before_reset", 64'(VGA_BLANK), 64'd1);
        #3 resetn = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (2) @(negedge clock);
        #3 resetn = 1'b1;
        #1 check_reset_values("release2");

        while (cyc != 27000) @(negedge clock);
        check_stats("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_framebuffer_scanout.md
Name: vga_framebuffer_scanout

Overview:
Read side of the pixel framebuffer: the plot path writes colour at (x,y) into a 160x120 pixel memory, and this block reads that memory back continuously to drive the VGA DAC. It generates 640x480@60 timing from CLOCK_50 using a divide-by-2 pixel enable. Each framebuffer pixel is scaled 4x4 onto the screen. The framebuffer memory is an external synchronous RAM read port with 1-clock read latency.

Parameters:
BITS_PER_COLOUR_CHANNEL, 1, bits per R/G/B channel in each memory word; legal values 1..3.
H_VISIBLE, 640, visible pixel ticks per line.
H_SYNC_START, 656, first h count with HS asserted.
H_SYNC_END, 752, first h count after HS.
H_TOTAL, 800, pixel ticks per line.
V_VISIBLE, 480, visible lines per frame.
V_SYNC_START, 490, first line with VS asserted.
V_SYNC_END, 492, first line after VS.
V_TOTAL, 525, lines per frame.

Ports:
clock  in  1  system clock (CLOCK_50).
resetn  in  1  asynchronous active-low reset.
rd_addr  out  15  framebuffer read address, y*160+x.
rd_data  in  3*BITS_PER_COLOUR_CHANNEL  memory word, valid 1 clock after rd_addr is sampled; {R,G,B}, R in the MSBs.
frame_start  out  1  one-clock pulse when the (0,0) address is presented.
VGA_CLK  out  1  25 MHz pixel clock to the DAC.
VGA_HS  out  1  horizontal sync, active low.
VGA_VS  out  1  vertical sync, active low.
VGA_BLANK  out  1  high in the visible region, low in blanking.
VGA_SYNC  out  1  constant 1.
VGA_R / VGA_G / VGA_B  out  10 each  DAC colour channels.

Behaviour:
- Reset values (async on resetn low): phase=0, h=0, v=0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0, VGA_R/G/B=0, frame_start=0, VGA_CLK=0. rd_addr=0 because it is derived from the counters.
- phase toggles every clock. pix_en = (phase==1). VGA_CLK = phase, so it rises one clock after every output update.
- Counters advance only when pix_en=1.
  - h runs 0..H_TOTAL-1, then wraps to 0.
  - When h wraps, v increments; v wraps to 0 after V_TOTAL-1.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap in the same tick.
- Address: x = h[9:2] (0..159) and y = v[8:2] (0..119) while visible. rd_addr = (y<<7)+(y<<5)+x, computed combinationally from the registered counters.
  - Maximum address is 19199.
  - Outside the visible region rd_addr is don't-care but must stay ≤ 19199: clamp to 0 when h≥H_VISIBLE or v≥V_VISIBLE.
- Pipeline and alignment:
  - Edge E0 (end of a pix_en cycle): counters load (h,v).
  - Edge E1: the RAM samples rd_addr.
  - During the next pix_en cycle, rd_data is valid.
  - Edge E2: the output registers capture colour and sync/blank, all computed from the same (h,v). The counters advance at E2 as well.
  - Latency from counter load to DAC output is 1 pixel tick (2 clocks). All VGA outputs change only at the end of pix_en cycles.
- Sync: VGA_HS=0 iff H_SYNC_START ≤ h < H_SYNC_END. VGA_VS=0 iff V_SYNC_START ≤ v < V_SYNC_END.
- Blank: visible = (h<H_VISIBLE && v<V_VISIBLE). VGA_BLANK = visible.
- Colour: when not visible, R/G/B = 0 regardless of rd_data. When visible, each channel's B bits are tiled MSB-first to fill 10 bits; for B=1, all 10 bits equal the channel bit.
- frame_start is high for exactly one clock: the pix_en cycle in which h=0 and v=0. After reset release, the first pulse comes in clock 2.
- Reset mid-frame: all state returns to reset values immediately. Scan restarts at (0,0) with no partial-line artefacts: outputs hold their reset values until the first E2.

Test Plan:
- Reset, then release → HS=VS=1, BLANK=0, RGB=0, rd_addr=0. frame_start pulses at clock 2 after release, then every 840000 clocks.
- Free run one line → HS period 1600 clocks, HS low 192 clocks; HS falls 2 clocks after the tick where h=656 loads. BLANK high 1280 clocks per visible line.
- Free run one frame → VS period 840000 clocks, VS low 3200 clocks (lines 490-491). BLANK low on all of lines 480-524.
- Address probes → (h=4,v=4) gives 161; (h=639,v=479) gives 19199; (h=700,v=100) gives 0; (h=3,v=3) gives 0.
- Memory model returns 3'b101 at all addresses → visible RGB = 10'h3FF / 10'h000 / 10'h3FF. Memory returns 3'b111 → RGB = 0 whenever BLANK=0.
- Per-address memory pattern (colour = addr[2:0]) → the output at screen pixel (h,v) matches memory[(v/4)*160+h/4] exactly 2 clocks after the counters load. Assert resetn low at h=300,v=200 → outputs go to reset values asynchronously, and the scan restarts from (0,0).
